// File: rtl/gray_seq_ctrl.sv
// -----------------------------------------------------------------------------
// gray_seq_ctrl
//
// Scans a binary index from a start code to an end code, one step per
// downstream transfer, and presents each index together with its Gray code.
// The scan may count up or down and may wrap through the all-ones/zero
// boundary. Each word is held for as long as the consumer stalls.
//
// Ports
//   clk    in   1        clock, all state changes on the rising edge
//   rst_n  in   1        asynchronous active-low reset
//   start  in   1        begin a scan (only looked at while idle)
//   abort  in   1        drop the scan in progress, back to idle
//   dir    in   1        0 = count up, 1 = count down (captured at start)
//   first  in   WIDTH    scan start code (captured at start)
//   last   in   WIDTH    scan end code (captured at start)
//   ready  in   1        downstream accepts the word offered this cycle
//   bin    out  WIDTH    current binary index
//   gray   out  WIDTH    Gray code of bin
//   valid  out  1        bin/gray hold a word offered downstream
//   busy   out  1        scan in progress (same as valid)
//   done   out  1        one-cycle pulse after the final transfer
//   count  out  WIDTH+1  words transferred in the current or last scan
// -----------------------------------------------------------------------------
module gray_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             dir,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] last,
  input  logic             ready,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] BIN_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   CNT_ONE = {{WIDTH{1'b0}}, 1'b1};

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] bin_reg,   bin_next;
  logic [WIDTH:0]   count_reg, count_next;
  logic             dir_reg,   dir_next;
  logic [WIDTH-1:0] last_reg,  last_next;

  logic             xfer;
  logic             at_last;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      bin_reg   <= '0;
      count_reg <= '0;
      dir_reg   <= 1'b0;
      last_reg  <= '0;
    end else begin
      state_reg <= state_next;
      bin_reg   <= bin_next;
      count_reg <= count_next;
      dir_reg   <= dir_next;
      last_reg  <= last_next;
    end
  end

  // A transfer only exists in RUN and only when abort is not pulling the
  // scan down; abort wins over both ready and completion.
  assign xfer    = (state_reg == RUN) && ready && !abort;
  assign at_last = (bin_reg == last_reg);

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    bin_next   = bin_reg;
    count_next = count_reg;
    dir_next   = dir_reg;
    last_next  = last_reg;

    case (state_reg)
      IDLE: begin
        // bin and count keep the results of the previous scan while idle.
        if (start && !abort) begin
          state_next = RUN;
          bin_next   = first;
          count_next = '0;
          dir_next   = dir;
          last_next  = last;
        end
      end

      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (xfer) begin
          count_next = count_reg + CNT_ONE;
          if (at_last) begin
            // The final word stays on bin so the result is visible afterwards.
            state_next = DONE;
          end else if (dir_reg) begin
            // Modular arithmetic gives the wrap 0 -> all-ones for free.
            bin_next = bin_reg - BIN_ONE;
          end else begin
            bin_next = bin_reg + BIN_ONE;
          end
        end
      end

      DONE: begin
        // Single-cycle pulse state; abort also lands in IDLE, so there is
        // nothing extra to do for it here.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bin   = bin_reg;
  assign count = count_reg;
  assign valid = (state_reg == RUN);
  assign busy  = valid;
  assign done  = (state_reg == DONE);

  // Gray code straight from the bin register: each bit is the XOR of the
  // matching binary bit and its upper neighbour, the MSB passes through.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
      assign gray[gi] = bin_reg[gi] ^ bin_reg[gi+1];
    end
  endgenerate
  assign gray[WIDTH-1] = bin_reg[WIDTH-1];

endmodule

// File: doc/gray_seq_ctrl.md
GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the code width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset; asynchronous assertion, active-low.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a scan; sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1 bit, which terminates any scan in progress.
REQ-006 The block SHALL have port dir, input, 1 bit: 0 = count up, 1 = count down; latched at start.
REQ-007 The block SHALL have port first, input, WIDTH bits, the scan start code; latched at start.
REQ-008 The block SHALL have port last, input, WIDTH bits, the scan end code; latched at start.
REQ-009 The block SHALL have port ready, input, 1 bit, the downstream accept signal.
REQ-010 The block SHALL have port bin, output, WIDTH bits, the current binary index.
REQ-011 The block SHALL have port gray, output, WIDTH bits, the Gray code of bin.
REQ-012 The block SHALL have port valid, output, 1 bit, meaning bin/gray hold a word offered downstream.
REQ-013 The block SHALL have port busy, output, 1 bit, high in RUN.
REQ-014 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-015 The block SHALL have port count, output, WIDTH+1 bits, the number of words transferred in the current or last scan.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 The block SHALL drive gray = bin ^ (bin >> 1) combinationally from the bin register, so gray and bin always correspond in the same cycle.
REQ-018 In IDLE with start=1 and abort=0, the block SHALL on the next edge latch dir/first/last, load bin=first, clear count and enter RUN.
REQ-019 The block SHALL hold valid=1 exactly while in RUN (first valid word one cycle after start), and busy=valid.
REQ-020 A transfer SHALL occur on an edge where valid=1 and ready=1; on each transfer count SHALL increment by 1.
REQ-021 On a transfer with bin != latched last, bin SHALL step by +1 (dir=0) or -1 (dir=1), modulo 2^WIDTH.
REQ-022 Wrap-around SHALL be permitted: up from all-ones gives 0, down from 0 gives all-ones; scans crossing the boundary SHALL be legal.
REQ-023 On a transfer with bin == latched last, the block SHALL enter DONE with bin held.
REQ-024 With valid=1 and ready=0, bin, gray and count SHALL hold stable with no limit on stall length.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE; done SHALL be 0 in all other states.
REQ-026 When first == last, the scan SHALL yield exactly one transfer.
REQ-027 A full scan SHALL yield ((last - first) mod 2^WIDTH) + 1 words for dir=0 and ((first - last) mod 2^WIDTH) + 1 for dir=1.
REQ-028 abort=1 in RUN or DONE SHALL move the FSM to IDLE on the next edge with no transfer counted that cycle and no done pulse; abort SHALL take priority over start, ready and completion.
REQ-029 Start asserted in RUN or DONE SHALL be ignored, and changes to dir/first/last during a scan SHALL have no effect.
REQ-030 In IDLE, bin and count SHALL hold their last values.

Reset
REQ-031 When rst_n=0, the block SHALL immediately, without waiting for a clock edge, force state=IDLE, bin=0 (so gray=0), count=0, valid=0, busy=0 and done=0.
REQ-032 Reset asserted mid-scan SHALL discard the scan; after release the block SHALL need a new start.
REQ-033 The first edge after rst_n rises SHALL be able to accept start.

Verification
REQ-034 The bench SHALL check an up scan with first=0, last=15, ready=1: 16 transfers, gray sequence 0000,0001,0011,0010,...,1000, done pulse, count=16.
REQ-035 The bench SHALL check a down scan with wrap, first=2, last=14, dir=1: bin sequence 2,1,0,15,14, count=5, one done pulse.
REQ-036 The bench SHALL check backpressure with ready toggling 1,0,0,1: bin/gray stable during the low cycles, no skipped or duplicated codes.
REQ-037 The bench SHALL check first=last=9: a single transfer of bin=1001, gray=1101, then done.
REQ-038 The bench SHALL check abort after 3 transfers: valid drops next cycle, no done pulse, count=3, and a new start runs normally.
REQ-039 The bench SHALL check rst_n pulled low mid-scan between edges: outputs zero immediately, and start is accepted after release.
